// File: rtl/openframe_gpio_pkg.sv
// Shared types for the openframe GPIO controller: pad mode codes, drive-mode
// encodings, the per-pad control record and the sequencer states.
package openframe_gpio_pkg;

  typedef enum logic [2:0] {
    MODE_DISABLED   = 3'd0,
    MODE_INPUT      = 3'd1,
    MODE_PULLUP     = 3'd2,
    MODE_PULLDOWN   = 3'd3,
    MODE_OUTPUT     = 3'd4,
    MODE_BIDIR      = 3'd5,
    MODE_OPEN_DRAIN = 3'd6,
    MODE_ANALOG     = 3'd7
  } gpio_mode_e;

  localparam logic [2:0] DM_HIZ        = 3'b000;
  localparam logic [2:0] DM_INPUT      = 3'b001;
  localparam logic [2:0] DM_PULLUP     = 3'b010;
  localparam logic [2:0] DM_PULLDOWN   = 3'b011;
  localparam logic [2:0] DM_OPEN_DRAIN = 3'b100;
  localparam logic [2:0] DM_STRONG     = 3'b110;

  typedef struct packed {
    logic [2:0] dm;
    logic       inp_dis;
    logic       oeb;
    logic       out;
    logic       analog_en;
  } pad_ctrl_t;

  typedef enum logic {
    ST_IDLE,
    ST_BREAK
  } ctrl_state_e;

endpackage

// File: rtl/openframe_gpio_decode.sv
// Single-pad decoder: active mode plus live user data to the gpiov2 control
// bundle; brk parks the pad output (oeb=1, out=0) while keeping its dm/inp_dis.
module openframe_gpio_decode
  import openframe_gpio_pkg::*;
(
  input  gpio_mode_e mode,
  input  logic       brk,
  input  logic       user_out,
  input  logic       user_oeb,
  output pad_ctrl_t  ctrl
);

  always_comb begin
    ctrl = '{dm: DM_HIZ, inp_dis: 1'b1, oeb: 1'b1, out: 1'b0, analog_en: 1'b0};
    case (mode)
      MODE_DISABLED:   ctrl = '{dm: DM_HIZ,        inp_dis: 1'b1, oeb: 1'b1,     out: 1'b0,     analog_en: 1'b0};
      MODE_INPUT:      ctrl = '{dm: DM_INPUT,      inp_dis: 1'b0, oeb: 1'b1,     out: 1'b0,     analog_en: 1'b0};
      MODE_PULLUP:     ctrl = '{dm: DM_PULLUP,     inp_dis: 1'b0, oeb: 1'b0,     out: 1'b1,     analog_en: 1'b0};
      MODE_PULLDOWN:   ctrl = '{dm: DM_PULLDOWN,   inp_dis: 1'b0, oeb: 1'b0,     out: 1'b0,     analog_en: 1'b0};
      MODE_OUTPUT:     ctrl = '{dm: DM_STRONG,     inp_dis: 1'b1, oeb: 1'b0,     out: user_out, analog_en: 1'b0};
      MODE_BIDIR:      ctrl = '{dm: DM_STRONG,     inp_dis: 1'b0, oeb: user_oeb, out: user_out, analog_en: 1'b0};
      MODE_OPEN_DRAIN: ctrl = '{dm: DM_OPEN_DRAIN, inp_dis: 1'b0, oeb: 1'b0,     out: user_out, analog_en: 1'b0};
      MODE_ANALOG:     ctrl = '{dm: DM_HIZ,        inp_dis: 1'b1, oeb: 1'b1,     out: 1'b0,     analog_en: 1'b1};
    endcase
    if (brk) begin
      ctrl.oeb = 1'b1;
      ctrl.out = 1'b0;
    end
  end

endmodule

// File: rtl/openframe_gpio_ctrl.sv
// Openframe pad configuration controller: shadow/active mode tables with a
// fixed-length break-before-make commit sequence driving all pad controls.
module openframe_gpio_ctrl
  import openframe_gpio_pkg::*;
#(
  parameter int NUM_PADS      = 44,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [5:0]          cfg_addr,
  input  logic [2:0]          cfg_mode,
  input  logic                cfg_apply,
  output logic                busy,
  output logic                cfg_err,
  input  logic [NUM_PADS-1:0] user_out,
  input  logic [NUM_PADS-1:0] user_oeb,
  output logic [NUM_PADS-1:0] gpio_out,
  output logic [NUM_PADS-1:0] gpio_oeb,
  output logic [NUM_PADS-1:0] gpio_inp_dis,
  output logic [NUM_PADS-1:0] gpio_dm2,
  output logic [NUM_PADS-1:0] gpio_dm1,
  output logic [NUM_PADS-1:0] gpio_dm0,
  output logic [NUM_PADS-1:0] gpio_analog_en,
  output logic [NUM_PADS-1:0] gpio_ib_mode_sel,
  output logic [NUM_PADS-1:0] gpio_vtrip_sel,
  output logic [NUM_PADS-1:0] gpio_slow_sel,
  output logic [NUM_PADS-1:0] gpio_holdover,
  output logic [NUM_PADS-1:0] gpio_analog_sel,
  output logic [NUM_PADS-1:0] gpio_analog_pol
);

  localparam logic [6:0] PAD_LIMIT = 7'(NUM_PADS);
  localparam logic [7:0] LAST_CNT  = 8'(SETTLE_CYCLES - 1);

  ctrl_state_e state_q, state_d;
  logic [7:0]  cnt_q;
  logic        err_q;
  gpio_mode_e  shadow_q [NUM_PADS];
  gpio_mode_e  active_q [NUM_PADS];

  logic wr_fire, addr_ok, break_done;

  assign cfg_ready  = !wb_rst_i && (state_q == ST_IDLE);
  assign busy       = (state_q == ST_BREAK);
  assign cfg_err    = err_q;
  assign wr_fire    = cfg_valid && cfg_ready;
  assign addr_ok    = {1'b0, cfg_addr} < PAD_LIMIT;
  assign break_done = busy && (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_apply)  state_d = ST_BREAK;
      ST_BREAK: if (break_done) state_d = ST_IDLE;
    endcase
  end

  // A write landing with the apply edge is already in shadow_q when BREAK starts.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_PADS; i++) begin
        shadow_q[i] <= MODE_DISABLED;
        active_q[i] <= MODE_DISABLED;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= busy ? cnt_q + 8'd1 : 8'd0;
      if (wr_fire && !addr_ok) err_q <= 1'b1;
      for (int i = 0; i < NUM_PADS; i++) begin
        if (wr_fire && (cfg_addr == 6'(i))) shadow_q[i] <= gpio_mode_e'(cfg_mode);
        if (break_done)                     active_q[i] <= shadow_q[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    pad_ctrl_t pad_ctrl;

    openframe_gpio_decode u_decode (
      .mode     (active_q[i]),
      .brk      (busy && (shadow_q[i] != active_q[i])),
      .user_out (user_out[i]),
      .user_oeb (user_oeb[i]),
      .ctrl     (pad_ctrl)
    );

    assign gpio_dm2[i]       = pad_ctrl.dm[2];
    assign gpio_dm1[i]       = pad_ctrl.dm[1];
    assign gpio_dm0[i]       = pad_ctrl.dm[0];
    assign gpio_inp_dis[i]   = pad_ctrl.inp_dis;
    assign gpio_oeb[i]       = pad_ctrl.oeb;
    assign gpio_out[i]       = pad_ctrl.out;
    assign gpio_analog_en[i] = pad_ctrl.analog_en;
  end

  assign gpio_ib_mode_sel = '0;
  assign gpio_vtrip_sel   = '0;
  assign gpio_slow_sel    = '0;
  assign gpio_holdover    = '0;
  assign gpio_analog_sel  = '0;
  assign gpio_analog_pol  = '0;

endmodule

// File: tb/tb_openframe_gpio_ctrl.sv
// Directed bench for openframe_gpio_ctrl: stimulus pushes hand-computed pad and
// control expectations, a negedge monitor pops and compares them.
module tb_openframe_gpio_ctrl;
  import openframe_gpio_pkg::*;

  localparam int NP = 44;

  logic          clk = 1'b0;
  logic          wb_rst_i;
  logic          cfg_valid, cfg_ready, cfg_apply, busy, cfg_err;
  logic [5:0]    cfg_addr;
  logic [2:0]    cfg_mode;
  logic [NP-1:0] user_out, user_oeb;
  logic [NP-1:0] gpio_out, gpio_oeb, gpio_inp_dis, gpio_dm2, gpio_dm1, gpio_dm0, gpio_analog_en;
  logic [NP-1:0] gpio_ib_mode_sel, gpio_vtrip_sel, gpio_slow_sel, gpio_holdover, gpio_analog_sel, gpio_analog_pol;

  always #5 clk = ~clk;

  openframe_gpio_ctrl #(.NUM_PADS(NP), .SETTLE_CYCLES(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .cfg_apply(cfg_apply), .busy(busy), .cfg_err(cfg_err),
    .user_out(user_out), .user_oeb(user_oeb),
    .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .gpio_inp_dis(gpio_inp_dis),
    .gpio_dm2(gpio_dm2), .gpio_dm1(gpio_dm1), .gpio_dm0(gpio_dm0), .gpio_analog_en(gpio_analog_en),
    .gpio_ib_mode_sel(gpio_ib_mode_sel), .gpio_vtrip_sel(gpio_vtrip_sel), .gpio_slow_sel(gpio_slow_sel),
    .gpio_holdover(gpio_holdover), .gpio_analog_sel(gpio_analog_sel), .gpio_analog_pol(gpio_analog_pol)
  );

  // Scoreboard: kind 0 = control {busy,ready,err}, 1 = one pad, 2 = all pads disabled
  string      nm_q[$];
  int         kind_q[$];
  int         pad_q[$];
  logic [6:0] pv_q[$];
  logic [2:0] cv_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk_ctl(input string nm, input logic b, input logic r, input logic e);
    nm_q.push_back(nm); kind_q.push_back(0); pad_q.push_back(0);
    pv_q.push_back(7'd0); cv_q.push_back({b, r, e});
  endtask

  // pv = {dm[2:0], inp_dis, oeb, out, analog_en}
  task automatic chk_pad(input string nm, input int p, input logic [6:0] pv);
    nm_q.push_back(nm); kind_q.push_back(1); pad_q.push_back(p);
    pv_q.push_back(pv); cv_q.push_back(3'd0);
  endtask

  task automatic chk_all(input string nm);
    nm_q.push_back(nm); kind_q.push_back(2); pad_q.push_back(0);
    pv_q.push_back(7'b000_1100); cv_q.push_back(3'd0);
  endtask

  function automatic logic [6:0] pad_now(input int p);
    return {gpio_dm2[p], gpio_dm1[p], gpio_dm0[p], gpio_inp_dis[p], gpio_oeb[p], gpio_out[p], gpio_analog_en[p]};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      while (nm_q.size() > 0) begin
        string      nm;
        int         k, p;
        logic [6:0] pv;
        logic [2:0] cv;
        nm = nm_q.pop_front(); k = kind_q.pop_front(); p = pad_q.pop_front();
        pv = pv_q.pop_front(); cv = cv_q.pop_front();
        checks++;
        if (k == 0) begin
          if ({busy, cfg_ready, cfg_err} !== cv) begin
            errors++;
            $display("FAIL %s: busy/ready/err got %b want %b", nm, {busy, cfg_ready, cfg_err}, cv);
          end
        end else if (k == 1) begin
          if (pad_now(p) !== pv) begin
            errors++;
            $display("FAIL %s: pad %0d dm/inp_dis/oeb/out/an got %b want %b", nm, p, pad_now(p), pv);
          end
        end else begin
          logic bad;
          bad = (|{gpio_ib_mode_sel, gpio_vtrip_sel, gpio_slow_sel,
                   gpio_holdover, gpio_analog_sel, gpio_analog_pol}) !== 1'b0;
          for (int i = 0; i < NP; i++) if (pad_now(i) !== pv) bad = 1'b1;
          if (bad) begin
            errors++;
            $display("FAIL %s: oeb=%h inp_dis=%h dm=%h/%h/%h out=%h an=%h want all disabled",
                     nm, gpio_oeb, gpio_inp_dis, gpio_dm2, gpio_dm1, gpio_dm0, gpio_out, gpio_analog_en);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_apply = 1'b0;
  endtask

  task automatic write(input logic [5:0] a, input gpio_mode_e m);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_mode  = m;
  endtask

  localparam logic [6:0] P_DIS = 7'b000_1100;

  initial begin
    wb_rst_i = 1'b1; cfg_valid = 1'b0; cfg_apply = 1'b0;
    cfg_addr = '0; cfg_mode = '0; user_out = '0; user_oeb = '1;

    // Reset behaviour
    tick(); tick();
    chk_ctl("rst_held_ctl", 0, 0, 0); chk_all("rst_held_pads");
    tick();
    wb_rst_i = 1'b0;
    chk_ctl("post_rst_ctl", 0, 1, 0); chk_all("post_rst_pads");

    // Pad 5 -> OUTPUT with break-before-make
    tick();
    write(6'd5, MODE_OUTPUT); user_out[5] = 1'b1;
    chk_ctl("wr_ready", 0, 1, 0);
    tick();
    cfg_apply = 1'b1;
    chk_pad("shadow_hidden", 5, P_DIS);
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk_ctl("brk_ctl", 1, 0, 0); chk_pad("brk_p5", 5, 7'b000_1100);
      tick();
    end
    chk_ctl("apply_done", 0, 1, 0); chk_pad("p5_out_hi", 5, 7'b110_1010);
    tick();
    user_out[5] = 1'b0;
    chk_pad("p5_out_lo", 5, 7'b110_1000);

    // Pad 3 OUTPUT, pad 7 BIDIR (write+apply same cycle)
    tick();
    write(6'd3, MODE_OUTPUT); user_out[3] = 1'b1;
    tick();
    write(6'd7, MODE_BIDIR); cfg_apply = 1'b1; user_out[7] = 1'b1; user_oeb[7] = 1'b0;
    tick();
    repeat (4) tick();
    chk_pad("p7_bidir", 7, 7'b110_0010); chk_pad("p3_out", 3, 7'b110_1010);
    chk_pad("p5_keep", 5, 7'b110_1000);
    tick();
    user_oeb[7] = 1'b1;
    chk_pad("p7_user_oeb", 7, 7'b110_0110);
    tick();
    user_oeb[7] = 1'b0;
    write(6'd7, MODE_INPUT); cfg_apply = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk_pad("brk_p7", 7, 7'b110_0100); chk_pad("brk_p3_drive", 3, 7'b110_1010);
      tick();
    end
    chk_pad("p7_input", 7, 7'b001_0100); chk_ctl("p7_done", 0, 1, 0);

    // Out-of-range write, ignored apply/write while busy, fixed latency
    tick();
    write(6'd50, MODE_OUTPUT);
    chk_ctl("bad_addr_rdy", 0, 1, 0);
    tick();
    chk_ctl("bad_addr_err", 0, 1, 1); chk_pad("p18_alias", 18, P_DIS);
    cfg_apply = 1'b1;
    tick();
    chk_ctl("nochg_busy", 1, 0, 1);
    tick();
    write(6'd9, MODE_OUTPUT); cfg_apply = 1'b1; user_out[9] = 1'b1;
    chk_ctl("busy_no_rdy", 1, 0, 1);
    tick(); tick();
    chk_ctl("busy_t4", 1, 0, 1);
    tick();
    chk_ctl("fixed_latency", 0, 1, 1); chk_pad("p9_dropped", 9, P_DIS);
    tick();
    chk_ctl("no_queued_apply", 0, 1, 1);
    cfg_apply = 1'b1;
    tick();
    repeat (4) tick();
    chk_pad("p9_never_written", 9, P_DIS);

    // Same-cycle write pad 0 ANALOG + apply
    tick();
    write(6'd0, MODE_ANALOG); cfg_apply = 1'b1;
    tick();
    repeat (3) tick();
    chk_pad("brk_p0", 0, P_DIS); chk_ctl("brk_p0_ctl", 1, 0, 1);
    tick();
    chk_pad("p0_analog", 0, 7'b000_1101); chk_ctl("p0_done", 0, 1, 1);

    // Reset in the middle of an apply
    tick();
    write(6'd12, MODE_PULLUP); cfg_apply = 1'b1;
    tick();
    tick();
    wb_rst_i = 1'b1;
    chk_ctl("rst_mid_apply", 1, 0, 1);
    tick();
    wb_rst_i = 1'b0;
    chk_ctl("rst_abandon_ctl", 0, 1, 0); chk_all("rst_abandon_pads");
    repeat (3) tick();
    chk_ctl("rst_no_commit_ctl", 0, 1, 0); chk_pad("p12_no_commit", 12, P_DIS);
    cfg_apply = 1'b1;
    tick();
    repeat (4) tick();
    chk_pad("p12_shadow_cleared", 12, P_DIS); chk_pad("p3_shadow_cleared", 3, P_DIS);

    // Remaining decodes and address boundary
    tick();
    write(6'd20, MODE_PULLUP);
    tick();
    write(6'd21, MODE_PULLDOWN);
    tick();
    write(6'd22, MODE_OPEN_DRAIN); user_out[22] = 1'b1;
    tick();
    write(6'd43, MODE_INPUT);
    tick();
    write(6'd44, MODE_OUTPUT); cfg_apply = 1'b1;
    tick();
    repeat (4) tick();
    chk_pad("p20_pullup", 20, 7'b010_0010); chk_pad("p21_pulldown", 21, 7'b011_0000);
    chk_pad("p22_od_hi", 22, 7'b100_0010); chk_pad("p43_input", 43, 7'b001_0100);
    chk_ctl("addr44_err", 0, 1, 1);
    tick();
    user_out[22] = 1'b0;
    chk_pad("p22_od_lo", 22, 7'b100_0000);

    tick();
    @(negedge clk);
    #1;
    if (nm_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", nm_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
